// File: rtl/bs_pkg.sv
// Shared types and helpers for the two-board Battleship link.
// Holds the slave FSM encoding, the grid width and a 16-cell population count.
package bs_pkg;

   localparam int GRID_W = 16;

   typedef enum logic [1:0] {
      SETUP = 2'd0,
      PLAY  = 2'd1,
      DEAD  = 2'd2
   } slave_st_t;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + 5'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: synchronizes a raw push button, then changes the output
// level only after the synced input has disagreed with it for DEBOUNCE_CYC cycles.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 500000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic clr_n,
   input  logic clear_i,
   input  logic btn_i,
   output logic btn_o
);

   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   btn_q, btn_d;
   logic                   btn_s;

   assign btn_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync_q <= '0;
         cnt_q  <= '0;
         btn_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
         cnt_q  <= cnt_d;
         btn_q  <= btn_d;
      end
   end

   // Any cycle where input and output agree restarts the count, so glitches never accumulate.
   always_comb begin
      btn_d = btn_q;
      cnt_d = '0;
      if (clear_i) begin
         btn_d = 1'b0;
      end else if (btn_s != btn_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
            btn_d = btn_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   assign btn_o = btn_q;

endmodule

// File: rtl/slave_board_ctrl.sv
// Player-B controller: synchronizes the master's strobes and buses, runs the
// SETUP/PLAY/DEAD game FSM and keeps B's ship, attack, shot-history and hit registers.
module slave_board_ctrl
   import bs_pkg::*;
#(
   parameter int WIDTH        = GRID_W,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int SYNC_STAGES  = 2
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic [WIDTH-1:0] sw,
   input  logic             btn1,
   input  logic             btn2,
   input  logic             btn3,
   input  logic             ldr1b,
   input  logic             ldr2b,
   input  logic             clr_m,
   input  logic [2:0]       dispb,
   input  logic [WIDTH-1:0] a_attack,
   output logic             btn1b,
   output logic             btn2b,
   output logic             btn3b,
   output logic [WIDTH-1:0] b_attack,
   output logic             livb,
   output logic             okb,
   output logic [4:0]       hits,
   output logic [2:0]       word_sel
);

   // Cross-board synchronizers
   logic [SYNC_STAGES-1:0]            ldr1_sync_q, ldr2_sync_q, clrm_sync_q;
   logic [SYNC_STAGES-1:0][2:0]       disp_sync_q;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] a_sync_q;
   logic                              ldr1_last_q, ldr2_last_q;
   logic [WIDTH-1:0]                  a_hold_q, a_q;

   logic ldr1_s, ldr2_s, clr_s;
   logic ldr1_rise, ldr2_rise;
   logic [WIDTH-1:0] a_s;

   assign ldr1_s    = ldr1_sync_q[SYNC_STAGES-1];
   assign ldr2_s    = ldr2_sync_q[SYNC_STAGES-1];
   assign clr_s     = clrm_sync_q[SYNC_STAGES-1];
   assign a_s       = a_sync_q[SYNC_STAGES-1];
   assign ldr1_rise = ldr1_s & ~ldr1_last_q;
   assign ldr2_rise = ldr2_s & ~ldr2_last_q;

   // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ldr1_sync_q <= '0;
         ldr2_sync_q <= '0;
         clrm_sync_q <= '0;
         disp_sync_q <= '0;
         a_sync_q    <= '0;
         ldr1_last_q <= 1'b0;
         ldr2_last_q <= 1'b0;
         a_hold_q    <= '0;
         a_q         <= '0;
      end else begin
         ldr1_sync_q <= {ldr1_sync_q[SYNC_STAGES-2:0], ldr1b};
         ldr2_sync_q <= {ldr2_sync_q[SYNC_STAGES-2:0], ldr2b};
         clrm_sync_q <= {clrm_sync_q[SYNC_STAGES-2:0], clr_m};
         disp_sync_q <= {disp_sync_q[SYNC_STAGES-2:0], dispb};
         a_sync_q    <= {a_sync_q[SYNC_STAGES-2:0], a_attack};
         // Edge trackers run through a clear so a strobe coinciding with it is consumed.
         ldr1_last_q <= ldr1_s;
         ldr2_last_q <= ldr2_s;
         a_hold_q    <= a_s;
         if (clr_s) begin
            a_q <= '0;
         end else if (a_s == a_hold_q) begin
            a_q <= a_s;
         end
      end
   end

   // Game FSM and datapath
   slave_st_t        state_q, state_d;
   logic [WIDTH-1:0] ships_q, ships_d;
   logic [WIDTH-1:0] batt_q, batt_d;
   logic [WIDTH-1:0] prev_a_q, prev_a_d;
   logic [4:0]       hits_q, hits_d;
   logic             okb_q, okb_d;
   logic             livb_q, livb_d;

   logic [WIDTH-1:0] ships_hit;
   logic [4:0]       new_hits;
   logic [5:0]       hits_sum;
   logic [4:0]       hits_sat;
   logic             shot_ok;

   assign ships_hit = ships_q & ~a_q;
   assign new_hits  = popcount16(16'(ships_q & a_q & ~prev_a_q));
   assign hits_sum  = 6'(hits_q) + 6'(new_hits);
   assign hits_sat  = (hits_sum > 6'(WIDTH)) ? 5'(WIDTH) : hits_sum[4:0];
   assign shot_ok   = ((a_q & prev_a_q) == prev_a_q) &&
                      (popcount16(16'(a_q ^ prev_a_q)) == 5'd1);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= SETUP;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      if (clr_s) begin
         state_d = SETUP;
      end else begin
         case (state_q)
            SETUP:   if (ldr1_rise && (sw != '0)) state_d = PLAY;
            PLAY:    if (ldr1_rise && (ships_hit == '0)) state_d = DEAD;
            DEAD:    state_d = DEAD;
            default: state_d = SETUP;
         endcase
      end
   end

   // ldr1b and ldr2b edges are decoded independently, so both land in the same cycle.
   always_comb begin
      ships_d  = ships_q;
      batt_d   = batt_q;
      prev_a_d = prev_a_q;
      hits_d   = hits_q;
      okb_d    = 1'b0;
      if (clr_s) begin
         ships_d  = '0;
         batt_d   = '0;
         prev_a_d = '0;
         hits_d   = '0;
      end else begin
         case (state_q)
            SETUP: begin
               if (ldr1_rise) ships_d = sw;
            end
            PLAY: begin
               okb_d = shot_ok;
               if (ldr2_rise) batt_d = sw;
               if (ldr1_rise) begin
                  ships_d  = ships_hit;
                  hits_d   = hits_sat;
                  prev_a_d = a_q;
               end
            end
            default: ;
         endcase
      end
      livb_d = |ships_d;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         ships_q  <= '0;
         batt_q   <= '0;
         prev_a_q <= '0;
         hits_q   <= '0;
         okb_q    <= 1'b0;
         livb_q   <= 1'b0;
      end else begin
         ships_q  <= ships_d;
         batt_q   <= batt_d;
         prev_a_q <= prev_a_d;
         hits_q   <= hits_d;
         okb_q    <= okb_d;
         livb_q   <= livb_d;
      end
   end

   assign b_attack = batt_q;
   assign livb     = livb_q;
   assign okb      = okb_q;
   assign hits     = hits_q;
   assign word_sel = disp_sync_q[SYNC_STAGES-1];

   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .SYNC_STAGES(SYNC_STAGES)) u_btn1 (
      .clk(clk), .clr_n(clr_n), .clear_i(clr_s), .btn_i(btn1), .btn_o(btn1b)
   );
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .SYNC_STAGES(SYNC_STAGES)) u_btn2 (
      .clk(clk), .clr_n(clr_n), .clear_i(clr_s), .btn_i(btn2), .btn_o(btn2b)
   );
   btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .SYNC_STAGES(SYNC_STAGES)) u_btn3 (
      .clk(clk), .clr_n(clr_n), .clear_i(clr_s), .btn_i(btn3), .btn_o(btn3b)
   );

endmodule

// File: tb/tb_slave_board_ctrl.sv
// Scenario bench for slave_board_ctrl: a behavioural game model feeds a queue of
// expected values that each scenario pops and compares once the DUT has settled.
module tb_slave_board_ctrl;
   import bs_pkg::*;

   localparam int W    = 16;
   localparam int DEB  = 4;
   localparam int SYNC = 2;

   logic          clk = 1'b0;
   logic          clr_n = 1'b0;
   logic [W-1:0]  sw = '0;
   logic          btn1 = 1'b0, btn2 = 1'b0, btn3 = 1'b0;
   logic          ldr1b = 1'b0, ldr2b = 1'b0, clr_m = 1'b0;
   logic [2:0]    dispb = '0;
   logic [W-1:0]  a_attack = '0;
   logic          btn1b, btn2b, btn3b;
   logic [W-1:0]  b_attack;
   logic          livb, okb;
   logic [4:0]    hits;
   logic [2:0]    word_sel;

   always #5 clk = ~clk;

   slave_board_ctrl #(.WIDTH(W), .DEBOUNCE_CYC(DEB), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .clr_n(clr_n), .sw(sw),
      .btn1(btn1), .btn2(btn2), .btn3(btn3),
      .ldr1b(ldr1b), .ldr2b(ldr2b), .clr_m(clr_m), .dispb(dispb), .a_attack(a_attack),
      .btn1b(btn1b), .btn2b(btn2b), .btn3b(btn3b),
      .b_attack(b_attack), .livb(livb), .okb(okb), .hits(hits), .word_sel(word_sel)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] sb[$];
   logic [15:0] e;

   // Behavioural model of the game state
   logic [W-1:0] m_ships = '0, m_prev = '0, m_batt = '0, m_a = '0;
   logic [4:0]   m_hits = '0;
   slave_st_t    m_state = SETUP;

   function automatic logic m_okb();
      return (m_state == PLAY) && ((m_a & m_prev) == m_prev) && ($countones(m_a ^ m_prev) == 1);
   endfunction

   task automatic model_strobe(input logic l1, input logic l2);
      int h;
      if (l2 && m_state == PLAY) m_batt = sw;
      if (l1) begin
         if (m_state == SETUP) begin
            m_ships = sw;
            if (sw != '0) m_state = PLAY;
         end else if (m_state == PLAY) begin
            h = int'(m_hits) + $countones(m_ships & m_a & ~m_prev);
            m_hits  = (h > W) ? 5'(W) : 5'(h);
            m_ships = m_ships & ~m_a;
            m_prev  = m_a;
            if (m_ships == '0) m_state = DEAD;
         end
      end
   endtask

   task automatic model_clear();
      m_ships = '0; m_prev = '0; m_batt = '0; m_hits = '0; m_state = SETUP;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic l1, input logic l2);
      model_strobe(l1, l2);
      @(negedge clk);
      ldr1b = l1; ldr2b = l2;
      tick(3);
      ldr1b = 1'b0; ldr2b = 1'b0;
      tick(6);
   endtask

   task automatic set_a(input logic [W-1:0] v);
      @(negedge clk);
      a_attack = v; m_a = v;
      tick(8);
   endtask

   task automatic pulse_clr_m();
      model_clear();
      @(negedge clk);
      clr_m = 1'b1;
      tick(3);
      clr_m = 1'b0;
      tick(6);
   endtask

   task automatic test_reset();
      clr_n = 1'b0;
      tick(3);
      clr_n = 1'b1;
      tick(2);
      sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0); sb.push_back(16'h0);
      sb.push_back(16'h0); sb.push_back(16'(SETUP));
      e = sb.pop_front(); n_cmp++;
      if (16'(b_attack) !== e) begin n_bad++; $display("FAIL reset_b_attack: got %h want %h", b_attack, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'({livb, okb}) !== e) begin n_bad++; $display("FAIL reset_livb_okb: got %b%b want %h", livb, okb, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(hits) !== e) begin n_bad++; $display("FAIL reset_hits: got %0d want %0d", hits, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(word_sel) !== e) begin n_bad++; $display("FAIL reset_word_sel: got %0d want %0d", word_sel, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'({btn1b, btn2b, btn3b}) !== e) begin n_bad++; $display("FAIL reset_buttons: got %b%b%b want 0", btn1b, btn2b, btn3b); end
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, e); end
   endtask

   task automatic test_setup_load();
      int  cyc;
      logic seen;
      // ldr2b in SETUP is ignored
      sw = 16'hBEEF;
      strobe(1'b0, 1'b1);
      sb.push_back(m_batt);
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL setup_ldr2_ignored: got %h want %h", b_attack, e); end
      // held strobe with sw=0 then sw changes: exactly one event, zero load keeps SETUP
      sw = '0;
      model_strobe(1'b1, 1'b0);
      @(negedge clk);
      ldr1b = 1'b1;
      tick(3);
      sw = 16'h00F0;
      tick(7);
      ldr1b = 1'b0;
      tick(6);
      sb.push_back(m_ships); sb.push_back(16'(m_state));
      e = sb.pop_front(); n_cmp++;
      if (dut.ships_q !== e) begin n_bad++; $display("FAIL held_strobe_ships: got %h want %h", dut.ships_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL held_strobe_state: got %0d want %0d", dut.state_q, e); end
      // real load, bounded latency
      model_strobe(1'b1, 1'b0);
      sb.push_back(16'h1);
      @(negedge clk);
      ldr1b = 1'b1;
      seen = 1'b0;
      for (cyc = 0; cyc < SYNC + 2; cyc++) begin
         @(posedge clk); #1;
         if (dut.ships_q == m_ships && dut.state_q == PLAY) seen = 1'b1;
      end
      e = sb.pop_front(); n_cmp++;
      if (16'(seen) !== e) begin n_bad++; $display("FAIL load_latency: loaded=%b want 1 within %0d clk", seen, SYNC + 2); end
      @(negedge clk);
      ldr1b = 1'b0;
      tick(6);
      sb.push_back(m_ships); sb.push_back(16'(m_state)); sb.push_back(16'(|m_ships));
      e = sb.pop_front(); n_cmp++;
      if (dut.ships_q !== e) begin n_bad++; $display("FAIL load_ships: got %h want %h", dut.ships_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL load_state: got %0d want %0d", dut.state_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(livb) !== e) begin n_bad++; $display("FAIL load_livb: got %b want %h", livb, e); end
      sw = 16'h1234;
      strobe(1'b0, 1'b1);
      sb.push_back(m_batt);
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL play_attack_load: got %h want %h", b_attack, e); end
   endtask

   task automatic test_shot_valid();
      logic [15:0] shots [2] = '{16'h0010, 16'h0030};
      foreach (shots[i]) begin
         set_a(shots[i]);
         sb.push_back(16'(m_okb()));
         e = sb.pop_front(); n_cmp++;
         if (16'(okb) !== e) begin n_bad++; $display("FAIL okb_shot_%h: got %b want %h", shots[i], okb, e); end
      end
   endtask

   task automatic test_hit_apply();
      logic [15:0] shots [3] = '{16'h0010, 16'h0011, 16'h00F1};
      foreach (shots[i]) begin
         set_a(shots[i]);
         sb.push_back(16'(m_okb()));
         e = sb.pop_front(); n_cmp++;
         if (16'(okb) !== e) begin n_bad++; $display("FAIL okb_pre_%h: got %b want %h", shots[i], okb, e); end
         strobe(1'b1, 1'b0);
         sb.push_back(m_ships); sb.push_back(16'(m_hits)); sb.push_back(16'(|m_ships));
         e = sb.pop_front(); n_cmp++;
         if (dut.ships_q !== e) begin n_bad++; $display("FAIL hit_ships_%h: got %h want %h", shots[i], dut.ships_q, e); end
         e = sb.pop_front(); n_cmp++;
         if (16'(hits) !== e) begin n_bad++; $display("FAIL hit_count_%h: got %0d want %0d", shots[i], hits, e); end
         e = sb.pop_front(); n_cmp++;
         if (16'(livb) !== e) begin n_bad++; $display("FAIL hit_livb_%h: got %b want %h", shots[i], livb, e); end
         if (i == 0) begin
            set_a(16'h0020);
            sb.push_back(16'(m_okb()));
            e = sb.pop_front(); n_cmp++;
            if (16'(okb) !== e) begin n_bad++; $display("FAIL okb_bit_removed: got %b want %h", okb, e); end
         end
      end
      // DEAD ignores everything
      sw = 16'hFFFF;
      strobe(1'b1, 1'b1);
      sb.push_back(16'(m_state)); sb.push_back(m_batt); sb.push_back(16'(m_hits));
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL dead_state: got %0d want %0d", dut.state_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL dead_attack_hold: got %h want %h", b_attack, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(hits) !== e) begin n_bad++; $display("FAIL dead_hits_hold: got %0d want %0d", hits, e); end
   endtask

   task automatic test_clear_priority();
      pulse_clr_m();
      sb.push_back(16'(m_state)); sb.push_back(16'(m_hits));
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL clr_m_state: got %0d want %0d", dut.state_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(hits) !== e) begin n_bad++; $display("FAIL clr_m_hits: got %0d want %0d", hits, e); end
      set_a('0);
      sw = 16'h00F0;
      strobe(1'b1, 1'b0);
      sw = 16'h00FF;
      strobe(1'b0, 1'b1);
      sb.push_back(m_batt);
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL pre_clear_attack: got %h want %h", b_attack, e); end
      model_clear();
      sw = 16'h0F0F;
      @(negedge clk);
      clr_m = 1'b1; ldr1b = 1'b1; ldr2b = 1'b1;
      tick(3);
      clr_m = 1'b0;
      tick(2);
      ldr1b = 1'b0; ldr2b = 1'b0;
      tick(6);
      sb.push_back(m_ships); sb.push_back(m_batt); sb.push_back(16'(m_state));
      e = sb.pop_front(); n_cmp++;
      if (dut.ships_q !== e) begin n_bad++; $display("FAIL clr_prio_ships: got %h want %h", dut.ships_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL clr_prio_attack: got %h want %h", b_attack, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL clr_prio_state: got %0d want %0d", dut.state_q, e); end
   endtask

   task automatic test_full_board();
      sw = 16'hFFFF;
      strobe(1'b1, 1'b0);
      set_a(16'hFFFF);
      sb.push_back(16'(m_okb()));
      e = sb.pop_front(); n_cmp++;
      if (16'(okb) !== e) begin n_bad++; $display("FAIL full_okb_many: got %b want %h", okb, e); end
      strobe(1'b1, 1'b0);
      sb.push_back(16'(m_hits)); sb.push_back(16'(m_state));
      e = sb.pop_front(); n_cmp++;
      if (16'(hits) !== e) begin n_bad++; $display("FAIL full_hits: got %0d want %0d", hits, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL full_state: got %0d want %0d", dut.state_q, e); end
      pulse_clr_m();
      set_a('0);
   endtask

   task automatic test_back_to_back();
      sw = 16'h000F;
      strobe(1'b1, 1'b0);
      set_a(16'h0001);
      sw = 16'hA5A5;
      strobe(1'b1, 1'b1);
      sb.push_back(m_ships); sb.push_back(16'(m_hits)); sb.push_back(m_batt); sb.push_back(16'(m_state));
      e = sb.pop_front(); n_cmp++;
      if (dut.ships_q !== e) begin n_bad++; $display("FAIL b2b_ships: got %h want %h", dut.ships_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(hits) !== e) begin n_bad++; $display("FAIL b2b_hits: got %0d want %0d", hits, e); end
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL b2b_attack: got %h want %h", b_attack, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(dut.state_q) !== e) begin n_bad++; $display("FAIL b2b_state: got %0d want %0d", dut.state_q, e); end
   endtask

   task automatic test_reset_mid_play();
      model_clear();
      sb.push_back(m_ships); sb.push_back(16'(m_hits)); sb.push_back(m_batt);
      @(negedge clk);
      #2 clr_n = 1'b0;
      #1;
      e = sb.pop_front(); n_cmp++;
      if (dut.ships_q !== e) begin n_bad++; $display("FAIL async_rst_ships: got %h want %h", dut.ships_q, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'(hits) !== e) begin n_bad++; $display("FAIL async_rst_hits: got %0d want %0d", hits, e); end
      e = sb.pop_front(); n_cmp++;
      if (b_attack !== e) begin n_bad++; $display("FAIL async_rst_attack: got %h want %h", b_attack, e); end
      @(negedge clk);
      clr_n = 1'b1;
      tick(2);
   endtask

   task automatic test_word_sel();
      sb.push_back(16'h0); sb.push_back(16'h5);
      @(negedge clk);
      dispb = 3'd5;
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (16'(word_sel) !== e) begin n_bad++; $display("FAIL word_sel_early: got %0d want %0d", word_sel, e); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (16'(word_sel) !== e) begin n_bad++; $display("FAIL word_sel_synced: got %0d want %0d", word_sel, e); end
   endtask

   task automatic test_debounce();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         btn2 = ((i % 6) < 3);
         if (btn2b) seen = 1'b1;
      end
      btn2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (btn2b) seen = 1'b1;
      end
      sb.push_back(16'h0);
      e = sb.pop_front(); n_cmp++;
      if (16'(seen) !== e) begin n_bad++; $display("FAIL debounce_glitch: btn2b went high=%b want 0", seen); end
      sb.push_back(16'h0); sb.push_back(16'h1); sb.push_back(16'h0); sb.push_back(16'h0);
      @(negedge clk);
      btn2 = 1'b1;
      repeat (DEB + SYNC - 1) @(posedge clk);
      #1;
      e = sb.pop_front(); n_cmp++;
      if (16'(btn2b) !== e) begin n_bad++; $display("FAIL debounce_too_early: got %b want %h", btn2b, e); end
      @(posedge clk); #1;
      e = sb.pop_front(); n_cmp++;
      if (16'(btn2b) !== e) begin n_bad++; $display("FAIL debounce_held: got %b want %h", btn2b, e); end
      e = sb.pop_front(); n_cmp++;
      if (16'({btn1b, btn3b}) !== e) begin n_bad++; $display("FAIL debounce_other_buttons: got %b%b want 0", btn1b, btn3b); end
      @(negedge clk);
      btn2 = 1'b0;
      repeat (DEB + SYNC) @(posedge clk);
      #1;
      e = sb.pop_front(); n_cmp++;
      if (16'(btn2b) !== e) begin n_bad++; $display("FAIL debounce_release: got %b want %h", btn2b, e); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_setup_load();
      test_shot_valid();
      test_hit_apply();
      test_clear_priority();
      test_full_board();
      test_back_to_back();
      test_reset_mid_play();
      test_word_sel();
      test_debounce();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
